// File: rtl/system_bus_pkg.sv
// Shared types and widths for the CPU system bus arbiter.
package system_bus_pkg;

  localparam int unsigned SYSTEM_BUS_ADDR_W = 32;
  localparam int unsigned SYSTEM_BUS_DATA_W = 32;
  localparam int unsigned SYSTEM_BUS_BE_W   = 4;

  // Owner of an outstanding read.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/read_owner_fifo.sv
// In-order FIFO recording which requester owns each outstanding bus read.
module read_owner_fifo
  import system_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  owner_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO never accepts a push, even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Owner storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_owner;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A read return with nothing outstanding is a bus protocol error; it is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && empty))
        else $warning("read return with no outstanding owner, dropped");
    end
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// Two-requester (IF / LS) system bus arbiter with in-order read return routing.
// Optional round-robin contention policy: define SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN.
module system_bus_arbiter
  import system_bus_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         if_ready,
  input  logic [SYSTEM_BUS_ADDR_W-1:0] if_addr,
  input  logic [SYSTEM_BUS_BE_W-1:0]   if_byte_enable,
  input  logic                         if_read_req,
  output logic [SYSTEM_BUS_DATA_W-1:0] if_read_data,
  output logic                         if_read_data_valid,
  output logic                         ls_ready,
  input  logic [SYSTEM_BUS_ADDR_W-1:0] ls_addr,
  input  logic [SYSTEM_BUS_BE_W-1:0]   ls_byte_enable,
  input  logic                         ls_read_req,
  input  logic                         ls_write_req,
  input  logic [SYSTEM_BUS_DATA_W-1:0] ls_write_data,
  output logic [SYSTEM_BUS_DATA_W-1:0] ls_read_data,
  output logic                         ls_read_data_valid,
  input  logic                         system_bus_ready,
  output logic [SYSTEM_BUS_ADDR_W-1:0] system_bus_addr,
  output logic [SYSTEM_BUS_BE_W-1:0]   system_bus_byte_enable,
  output logic                         system_bus_read_req,
  output logic                         system_bus_write_req,
  output logic [SYSTEM_BUS_DATA_W-1:0] system_bus_write_data,
  input  logic [SYSTEM_BUS_DATA_W-1:0] system_bus_read_data,
  input  logic                         system_bus_read_data_valid
);

  logic   ls_req;
  logic   prio_ls;
  logic   ls_wins;
  logic   if_fire;
  logic   ls_fire;
  logic   read_fire;
  logic   fifo_full;
  logic   fifo_empty;
  owner_t fifo_head;

  assign ls_req  = ls_read_req | ls_write_req;
  assign ls_wins = ls_req && (!if_read_req || prio_ls);

`ifdef SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
  owner_t last_grant;

  // Remember who was granted last so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWNER_IF;
    end else if (ls_fire) begin
      last_grant <= OWNER_LS;
    end else if (if_fire) begin
      last_grant <= OWNER_IF;
    end
  end

  assign prio_ls = (last_grant == OWNER_IF);
`else
  assign prio_ls = 1'b1;
`endif

  // Readys; LS writes bypass the owner FIFO so they are not blocked by it.
  always_comb begin
    if_ready = 1'b0;
    ls_ready = 1'b0;
    if (!reset) begin
      if_ready = system_bus_ready && !fifo_full && !ls_wins;
      ls_ready = system_bus_ready && ls_wins && (ls_write_req || !fifo_full);
    end
  end

  assign if_fire   = if_ready && if_read_req;
  assign ls_fire   = ls_ready && ls_req;
  assign read_fire = if_fire || (ls_fire && ls_read_req);

  // Bus request mux from the winning requester.
  always_comb begin
    system_bus_addr        = if_addr;
    system_bus_byte_enable = if_byte_enable;
    system_bus_write_data  = '0;
    if (ls_wins) begin
      system_bus_addr        = ls_addr;
      system_bus_byte_enable = ls_byte_enable;
      system_bus_write_data  = ls_write_data;
    end
    system_bus_read_req  = read_fire;
    system_bus_write_req = ls_fire && ls_write_req;
  end

  read_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (read_fire),
    .push_owner (ls_fire ? OWNER_LS : OWNER_IF),
    .pop        (system_bus_read_data_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Return routing to the owner at the FIFO head.
  always_comb begin
    if_read_data       = system_bus_read_data;
    ls_read_data       = system_bus_read_data;
    if_read_data_valid = 1'b0;
    ls_read_data_valid = 1'b0;
    if (!reset && system_bus_read_data_valid && !fifo_empty) begin
      if_read_data_valid = (fifo_head == OWNER_IF);
      ls_read_data_valid = (fifo_head == OWNER_LS);
    end
  end

endmodule
